// File: rtl/act_stream_pkg.sv
// act_stream_pkg
// Shared definitions for the activation-stage output buffers: default word
// width, the stored {last, data} word layout, the occupancy state encoding
// and a helper for sizing occupancy counters.
package act_stream_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // Stored FIFO entry at the default width: tile-framing bit above the payload.
    typedef struct packed {
        logic                      last;
        logic [DATA_W_DEFAULT-1:0] data;
    } act_word_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/swish_out_buffer_if.sv
// swish_out_buffer_if
// Stream bundle around the Swish output buffer.
//   valid_in / data_in        : free-running producer stream (no backpressure)
//   m_valid / m_ready / m_data / m_last : valid/ready consumer stream with tile framing
// Modports:
//   slave  - the buffer's view (consumes valid_in/data_in, produces m_*)
//   master - the environment's view (drives valid_in/data_in/m_ready)
interface swish_out_buffer_if
    import act_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  valid_in, data_in, m_ready,
        output m_valid, m_data, m_last
    );

    modport master (
        output valid_in, data_in, m_ready,
        input  m_valid, m_data, m_last
    );
endinterface

// File: rtl/act_sync_fifo.sv
// act_sync_fifo
// Synchronous first-word-fall-through FIFO shared by the activation stages.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push, pop  : write / read strobes, already qualified by the caller
//                (no push while full unless popping, no pop while empty)
//   wdata      : entry to write
//   rdata      : entry at the read pointer (valid while !empty)
//   level      : occupancy 0..DEPTH
//   empty/full : decoded from the registered occupancy state
module act_sync_fifo
    import act_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        empty,
    output logic                        full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    occ_state_t       state;

    // Storage carries no reset: stale contents are never visible because
    // the occupancy state marks them empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (state == OCC_EMPTY);
    assign full  = (state == OCC_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            state <= OCC_EMPTY;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;

            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;

            // Push and pop together leave the occupancy state untouched.
            case (state)
                OCC_EMPTY: begin
                    if (push) state <= OCC_PARTIAL;
                end
                OCC_PARTIAL: begin
                    if (push && !pop && level == LW'(DEPTH - 1))
                        state <= OCC_FULL;
                    else if (pop && !push && level == LW'(1))
                        state <= OCC_EMPTY;
                end
                OCC_FULL: begin
                    if (pop && !push) state <= OCC_PARTIAL;
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/swish_out_buffer.sv
// swish_out_buffer
// Elastic output stage after the Swish activation. Absorbs the valid-only
// Swish stream into a FIFO and re-presents it as a valid/ready stream with
// tile framing (m_last every TILE_LEN accepted words).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : stream bundle (valid_in/data_in in, m_valid/m_ready/m_data/m_last)
//   level        : FIFO occupancy
//   almost_full  : registered, high while level >= DEPTH-2
//   overflow     : sticky, set when a word is dropped on a full FIFO
//   clear_err    : clears overflow (a same-cycle drop takes priority)
module swish_out_buffer
    import act_stream_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TILE_LEN = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    swish_out_buffer_if.slave         bus,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      almost_full,
    output logic                      overflow,
    input  logic                      clear_err
);
    localparam int unsigned LW = level_w(DEPTH);
    localparam int unsigned CW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam int unsigned WW = DATA_W + 1;
    localparam logic [LW-1:0] AF_TH = LW'(DEPTH - 2);

    logic [CW-1:0] tile_cnt;
    logic          tile_last;
    logic          push;
    logic          pop;
    logic          drop;
    logic          empty;
    logic          full;
    logic [WW-1:0] wdata;
    logic [WW-1:0] rdata;
    logic [LW-1:0] level_nxt;

    assign pop       = !empty && bus.m_ready;
    assign push      = bus.valid_in && (!full || pop);
    assign drop      = bus.valid_in && full && !pop;
    assign tile_last = (32'(tile_cnt) == TILE_LEN - 1);
    assign wdata     = {tile_last, bus.data_in};

    act_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    // Head is zero-gated so stale storage never leaks onto the bus.
    assign bus.m_valid = !empty;
    assign bus.m_data  = empty ? '0 : rdata[DATA_W-1:0];
    assign bus.m_last  = !empty && rdata[DATA_W];

    // almost_full tracks the post-edge occupancy so it moves on the same
    // edge as the push/pop that changes level.
    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + 1'b1;
        else if (pop && !push) level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) tile_cnt <= tile_last ? '0 : tile_cnt + 1'b1;
            almost_full <= (level_nxt >= AF_TH);
            if (drop)           overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_swish_out_buffer.sv
// tb_swish_out_buffer
// Self-checking bench: fixed vector table, directed corner sequences and a
// randomized phase, all compared against a queue-based reference model.
module tb_swish_out_buffer;
    import act_stream_pkg::*;

    localparam int unsigned DW       = 32;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TILE_LEN = 4;
    localparam int unsigned LW       = level_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_err;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          overflow;

    swish_out_buffer_if #(.DATA_W(DW)) bus ();

    swish_out_buffer #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .TILE_LEN (TILE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } mword_t;

    mword_t      mq[$];
    int unsigned m_tcnt;
    logic        m_ovf;

    // words seen leaving the DUT (head sampled when m_valid && m_ready)
    mword_t      popped[$];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] dut_pack();
        return {23'd0, bus.m_valid, bus.m_last, almost_full, overflow, level, bus.m_data};
    endfunction

    function automatic logic [63:0] pack(input logic v, input logic l, input logic af,
                                         input logic ov, input int unsigned lv,
                                         input logic [DW-1:0] d);
        return {23'd0, v, l, af, ov, LW'(lv), d};
    endfunction

    function automatic logic [63:0] model_pack();
        logic          v;
        logic          l;
        logic [DW-1:0] d;
        v = (mq.size() > 0);
        l = v ? mq[0].last : 1'b0;
        d = v ? mq[0].data : '0;
        return pack(v, l, (mq.size() >= DEPTH - 2), m_ovf, mq.size(), d);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tcnt = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update(input logic vin, input logic [DW-1:0] din,
                                input logic rdy, input logic clr);
        logic   mpop;
        logic   mfull;
        logic   mpush;
        logic   mdrop;
        mword_t w;
        mpop  = (mq.size() > 0) && rdy;
        mfull = (mq.size() == DEPTH);
        mpush = vin && (!mfull || mpop);
        mdrop = vin && mfull && !mpop;
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
            w.last = (m_tcnt == TILE_LEN - 1);
            w.data = din;
            mq.push_back(w);
            m_tcnt = (m_tcnt + 1) % TILE_LEN;
        end
        if (mdrop)    m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(input logic vin, input logic [DW-1:0] din,
                        input logic rdy, input logic clr);
        logic          stalled;
        logic [DW-1:0] held_d;
        logic          held_l;
        mword_t        w;
        bus.valid_in = vin;
        bus.data_in  = din;
        bus.m_ready  = rdy;
        clear_err    = clr;
        stalled = bus.m_valid && !rdy;
        held_d  = bus.m_data;
        held_l  = bus.m_last;
        if (bus.m_valid && rdy) begin
            w.last = bus.m_last;
            w.data = bus.m_data;
            popped.push_back(w);
        end
        @(posedge clk);
        model_update(vin, din, rdy, clr);
        #1;
        check("model", dut_pack() === model_pack(), dut_pack(), model_pack());
        if (stalled)
            check("head_hold", bus.m_valid && bus.m_data === held_d && bus.m_last === held_l,
                  {31'd0, bus.m_last, bus.m_data}, {31'd0, held_l, held_d});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          vin;
        logic [DW-1:0] din;
        logic          rdy;
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        int unsigned   lvl;
        logic          af;
        logic          ovf;
    } vec_t;

    function automatic vec_t mk(input logic vin, input int unsigned din, input logic rdy,
                                input logic valid, input int unsigned data, input logic last,
                                input int unsigned lvl, input logic af, input logic ovf);
        vec_t v;
        v.vin = vin; v.din = DW'(din); v.rdy = rdy;
        v.valid = valid; v.data = DW'(data); v.last = last;
        v.lvl = lvl; v.af = af; v.ovf = ovf;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        logic [63:0] e;

        // 8 words through a ready consumer: head follows one cycle behind,
        // words 4 and 8 close tiles, then stalled words 9/10 accumulate.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1, i + 1, 1, 1, i + 1, ((i + 1) % 4 == 0), 1, 0, 0);
        tbl[8]  = mk(0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 9,  0, 1, 9, 0, 1, 0, 0);
        tbl[10] = mk(1, 10, 0, 1, 9, 0, 2, 0, 0);
        tbl[11] = mk(0, 0,  0, 1, 9, 0, 2, 0, 0);

        rst = 1'b1;
        clear_err = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.m_ready  = 1'b0;
        model_reset();
        #12;
        check("reset", dut_pack() === 64'd0, dut_pack(), 64'd0);
        rst = 1'b0;

        // ---- test 1: table ----
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].vin, tbl[i].din, tbl[i].rdy, 1'b0);
            e = pack(tbl[i].valid, tbl[i].last, tbl[i].af, tbl[i].ovf, tbl[i].lvl, tbl[i].data);
            check($sformatf("vec%0d", i), dut_pack() === e, dut_pack(), e);
        end

        // ---- test 6: async reset with level 9 ----
        for (int k = 11; k <= 17; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
        check("pre_rst_level", level === LW'(9), 64'(level), 64'd9);
        rst = 1'b1;
        #1;
        check("async_rst", dut_pack() === 64'd0, dut_pack(), 64'd0);
        model_reset();
        #2;
        rst = 1'b0;

        // ---- test 2: tile framing with random stalls ----
        popped.delete();
        for (int k = 1; k <= 10; k++) step(1'b1, DW'(k), 1'($urandom_range(0, 1)), 1'b0);
        cyc = 0;
        while (popped.size() < 10 && cyc < 80) begin
            step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
        end
        check("t2_count", popped.size() == 10, 64'(popped.size()), 64'd10);
        for (int k = 0; k < popped.size(); k++)
            check($sformatf("t2_word%0d", k + 1),
                  popped[k].data === DW'(k + 1) && popped[k].last === (k + 1 == 4 || k + 1 == 8),
                  {31'd0, popped[k].last, popped[k].data},
                  {31'd0, 1'(k + 1 == 4 || k + 1 == 8), DW'(k + 1)});

        // ---- test 3: fill with a stalled consumer ----
        for (int k = 1; k <= 18; k++) begin
            step(1'b1, DW'(k), 1'b0, 1'b0);
            if (k == 13) check("t3_af13", almost_full === 1'b0, 64'(almost_full), 64'd0);
            if (k == 14) check("t3_af14", almost_full === 1'b1, 64'(almost_full), 64'd1);
            if (k == 16) check("t3_ovf16", overflow === 1'b0, 64'(overflow), 64'd0);
        end
        check("t3_level", level === LW'(16), 64'(level), 64'd16);
        check("t3_ovf", overflow === 1'b1, 64'(overflow), 64'd1);

        // ---- test 5: set beats clear, then clear alone ----
        step(1'b1, DW'(19), 1'b0, 1'b1);
        check("t5_set_wins", overflow === 1'b1, 64'(overflow), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t5_clear", overflow === 1'b0, 64'(overflow), 64'd0);

        // ---- test 4: push into full FIFO while popping ----
        popped.delete();
        step(1'b1, DW'(100), 1'b1, 1'b0);
        check("t4_level", level === LW'(16), 64'(level), 64'd16);
        check("t4_ovf", overflow === 1'b0, 64'(overflow), 64'd0);

        // drain: words 1..16 then the word accepted while full
        cyc = 0;
        while (popped.size() < 17 && cyc < 40) begin
            step(1'b0, '0, 1'b1, 1'b0);
            cyc++;
        end
        check("drain_count", popped.size() == 17, 64'(popped.size()), 64'd17);
        for (int k = 0; k < popped.size(); k++)
            check($sformatf("drain%0d", k),
                  popped[k].data === ((k < 16) ? DW'(k + 1) : DW'(100)),
                  64'(popped[k].data), (k < 16) ? 64'(k + 1) : 64'd100);

        // ---- randomized phase ----
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), DW'($urandom),
                 (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/swish_out_buffer.md
# swish_out_buffer

Elastic output stage placed directly downstream of the Swish activation stage. It absorbs the Swish stage's free-running valid-only stream (no backpressure) into a FIFO and re-presents it as a valid/ready stream with tile framing (`m_last`) for the next operator or the result writer. It flags overflow when the consumer stalls too long, and gives the scheduler an early almost-full warning.

## Interface
Parameters:
- DATA_W, 32 — word width. Opaque payload: the block never inspects the bits.
- DEPTH, 16 — FIFO entries. Power of 2, at least 4.
- TILE_LEN, 256 — accepted words per tile. At least 1.

Ports:
- clk  in  1  — single clock; all logic is on the rising edge.
- rst  in  1  — asynchronous, active-high reset.
- valid_in  in  1  — Swish `valid_out`.
- data_in  in  DATA_W  — Swish `output_data`.
- m_valid  out  1  — head word is available.
- m_ready  in  1  — consumer accepts the head word.
- m_data  out  DATA_W  — head word.
- m_last  out  1  — head word is the last word of its tile.
- level  out  $clog2(DEPTH)+1  — current occupancy.
- almost_full  out  1  — registered; high when level ≥ DEPTH-2.
- overflow  out  1  — sticky flag: at least one word was dropped.
- clear_err  in  1  — clears `overflow`.

## Operation
- Push: asserted when `valid_in` is high and either not full, or full with a pop in the same cycle. The stored entry is {tile_last, data_in}.
- Pop: asserted when `m_valid && m_ready`.
- Drop: `valid_in` high while full with no pop. The word is discarded and `overflow` is set.
- Simultaneous `overflow` set and `clear_err`: set wins.
- Tile counter (0..TILE_LEN-1):
  - Advances on every push; dropped words are not counted.
  - tile_last = (count == TILE_LEN-1). The counter wraps to 0 after that push.
  - With TILE_LEN=1, every word has last=1.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `level` is a separate counter:
  - +1 on push only, -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Head is first-word-fall-through:
  - `m_data` and `m_last` show the entry at the read pointer while `m_valid` is high.
  - Both are forced to 0 when the FIFO is empty.
- The head word must hold stable while `m_valid && !m_ready`.
- Occupancy states: EMPTY (level=0), PARTIAL, FULL (level=DEPTH).
  - Transitions follow push/pop only. Push and pop together never change state.
  - In EMPTY no pop is possible (`m_valid`=0).

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, level=0, almost_full=0, overflow=0. Pointers and the tile counter also reset to 0.
- Reset mid-operation: contents are discarded immediately (asynchronous). The first push after reset starts a new tile at count 0.
- Latency:
  - A word pushed at edge k into an empty FIFO gives m_valid=1 in the cycle after edge k.
  - The pop at edge j shows the next entry immediately after edge j.
- Throughput: 1 word/cycle sustained when `m_ready` is held high.
- `almost_full` and `overflow` update on the same edge as the push/pop/drop that causes them.

## Structure
- Shared package `act_stream_pkg`:
  - default DATA_W;
  - typedef `act_word_t` = {last, data};
  - helper constant for the level width.
- Sub-module `act_sync_fifo`: register-array storage, pointers, level counter, full/empty. It is reusable by the other activation stages.
- Top level (`swish_out_buffer`) holds:
  - the tile counter;
  - push/drop qualification;
  - the overflow/clear logic;
  - almost_full;
  - output zero-gating.

## Test plan
1. Reset, then 8 words 1..8 with m_ready=1 → m_valid rises the cycle after the first push; data out is 1..8 in order; level ≤ 1; overflow=0.
2. TILE_LEN=4, 10 words, m_ready toggling randomly → m_last=1 on words 4 and 8 only; the head is stable during stalls.
3. DEPTH=16, m_ready=0, 18 pushes → almost_full rises at level 14; level saturates at 16; words 17 and 18 are dropped; overflow=1; a later drain yields exactly words 1..16.
4. FIFO full, valid_in=1 and m_ready=1 in the same cycle → push is accepted; level stays 16; overflow stays 0.
5. overflow=1, clear_err pulsed in the same cycle as a new drop → overflow stays 1. clear_err alone the next cycle → overflow=0.
6. Assert rst asynchronously while level=9 → all outputs go to reset values before the next edge; the next tile's m_last lands on word TILE_LEN after reset.
